nco_sweep_ctrl: RTL and testbench
=================================

# nco_sweep_ctrl

Sequencer that drives the NCO's phase-increment input and clock enable to produce a stepped-frequency sweep for the swept-source front end. It sits between the host/acquisition control logic and the NCO. On a start pulse it loads start frequency, step size, point count and dwell time. It then primes the NCO until its output-valid flag rises and steps the phase increment at fixed dwell intervals, raising a done pulse when the sweep finishes.

## Interface
- APR, 32, phase-increment width; must match the NCO accumulator width
- CNTW, 16, width of point count and point index
- DWW, 16, width of dwell count

Ports:
- clk  in  1  single clock for all logic
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request; honoured in IDLE only
- abort  in  1  terminates any sweep in progress
- start_inc  in  APR  phase increment of the first point
- step_inc  in  APR  two's-complement increment added per point
- n_pts  in  CNTW  points per sweep leg; 0 is treated as 1
- dwell  in  DWW  SWEEP cycles per point; 0 is treated as 1
- nco_valid  in  1  NCO out_valid
- phi_inc_o  out  APR  to NCO phi_inc_i
- nco_clken  out  1  to NCO clken
- busy  out  1  high in PRIME, SWEEP and DONE
- done  out  1  one-cycle pulse at normal completion
- step_tick  out  1  one-cycle pulse, coincident with each new phi_inc_o value
- pt_idx  out  CNTW  index of the current point
- dir  out  1  0 = up leg, 1 = down leg

## Operation
- States: IDLE, PRIME, SWEEP, DONE.
- IDLE + start (abort low):
  - latch start_inc, step_inc, n_last = max(n_pts,1)-1 and dwell_m1 = max(dwell,1)-1
  - phi_inc_o ← start_inc, pt_idx ← 0, dir ← 0
  - go to PRIME
- PRIME:
  - nco_clken = 1
  - when nco_valid is sampled high: dwell_cnt ← dwell_m1, go to SWEEP
  - if nco_valid is already high on the first PRIME cycle, PRIME lasts exactly 1 cycle
- SWEEP: nco_clken = 1. Each cycle:
  - if dwell_cnt ≠ 0: decrement dwell_cnt
  - if dwell_cnt = 0 and this is the last point: go to DONE
  - otherwise: phi_inc_o ← phi_inc_o ± step_inc (wraps mod 2^APR, no saturation); pt_idx ± 1; dwell_cnt ← dwell_m1; step_tick = 1
- DONE: done = 1 for one cycle, nco_clken = 0, then IDLE.
- phi_inc_o keeps its last value in IDLE.
- Abort in PRIME, SWEEP or DONE:
  - go to IDLE on the next edge; done is not pulsed
  - nco_clken and busy drop on that edge; phi_inc_o holds
- Abort and start in the same IDLE cycle: abort wins.
- start outside IDLE is ignored, with no queueing.
- Inputs other than start, abort and nco_valid are sampled only on the accepted start cycle.

## Timing
- Reset values: phi_inc_o = 0, nco_clken = 0, busy = 0, done = 0, step_tick = 0, pt_idx = 0, dir = 0; state is IDLE.
- All outputs are registered.
- start at edge k gives busy = 1 and nco_clken = 1 at k+1.
- SWEEP holds each point for exactly max(dwell,1) cycles. The first point is additionally held for the PRIME cycles.
- Single-leg sweep duration: PRIME cycles + n·d SWEEP cycles + 1 DONE cycle.

## Configuration
- NCO_SWEEP_BIDIR_EN defined:
  - triangle sweep; when the up leg reaches pt_idx = n_last with dwell expired, set dir ← 1, subtract step_inc and decrement pt_idx
  - the sweep ends after the pt_idx = 0 dwell of the down leg, for 2n−1 points total
  - with n_pts ≤ 1 it behaves as a single point
- NCO_SWEEP_BIDIR_EN undefined:
  - single up leg (sawtooth); dir is tied to 0

## Structure
- Package nco_sweep_pkg holds:
  - the state enum
  - localparams for the state encoding
  - the dir encoding (DIR_UP = 0, DIR_DN = 1)
- One sub-module, nco_sweep_timer: the dwell down-counter with load/decrement and a zero flag.
- The FSM and the phase-increment adder stay in the top level.

## Test plan
- Basic sweep: reset held then released → all outputs 0, state IDLE. Then start_inc = 0x0100_0000, step_inc = 0x0010_0000, n_pts = 4, dwell = 3, nco_valid high → phi_inc_o is 0x0100_0000 for 1 PRIME + 3 SWEEP cycles, then 0x0110_0000, 0x0120_0000 and 0x0130_0000 for 3 cycles each. step_tick fires 3 times, then done pulses once and busy falls the cycle after.
- Delayed valid: nco_valid rises 10 cycles after start → PRIME lasts 10 cycles with nco_clken = 1 and phi_inc_o = start_inc, then the SWEEP timing is as in the basic sweep.
- Wrap and degenerate values:
  - start_inc = 0xFFF0_0000, step_inc = 0x0020_0000, n_pts = 2 → second point is 0x0010_0000
  - n_pts = 0, dwell = 0 → one point, 1 SWEEP cycle, then done
- Abort and start collisions:
  - abort asserted mid-SWEEP at pt_idx = 2 → IDLE next cycle, no done, nco_clken = 0, phi_inc_o holds
  - start and abort in the same cycle → no sweep
  - start during busy → ignored
- Negative step: step_inc = 0xFFF0_0000 (−0x0010_0000), start_inc = 0x0200_0000, n_pts = 3 → points 0x0200_0000, 0x01F0_0000, 0x01E0_0000.
- NCO_SWEEP_BIDIR_EN defined, n_pts = 3, dwell = 2 → points 0, 1, 2, 1, 0 (pt_idx). dir goes high with the first down step, there are 4 step_ticks, and the last phi_inc_o equals start_inc.

Source files
------------

// File: rtl/nco_sweep_pkg.sv
// Shared types and encodings for the NCO stepped-frequency sweep sequencer.
package nco_sweep_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRIME = 2'd1;
    localparam logic [1:0] S_SWEEP = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_PRIME = S_PRIME,
        ST_SWEEP = S_SWEEP,
        ST_DONE  = S_DONE
    } state_e;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/nco_sweep_timer.sv
// Dwell down-counter: load has priority over decrement; zero_o flags an expired dwell.
module nco_sweep_timer
    import nco_sweep_pkg::*;
#(
    parameter int DWW = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           load_i,
    input  logic [DWW-1:0] load_val_i,
    input  logic           dec_i,
    output logic           zero_o
);

    localparam logic [DWW-1:0] DW_ONE = DWW'(1);

    logic [DWW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i) begin
            cnt_q <= cnt_q - DW_ONE;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Stepped-frequency sweep sequencer driving an NCO phase increment and clock enable.
// Define NCO_SWEEP_BIDIR_EN for a triangle (up then down) sweep; default is a single up leg.
module nco_sweep_ctrl
    import nco_sweep_pkg::*;
#(
    parameter int APR  = 32,
    parameter int CNTW = 16,
    parameter int DWW  = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            abort,
    input  logic [APR-1:0]  start_inc,
    input  logic [APR-1:0]  step_inc,
    input  logic [CNTW-1:0] n_pts,
    input  logic [DWW-1:0]  dwell,
    input  logic            nco_valid,
    output logic [APR-1:0]  phi_inc_o,
    output logic            nco_clken,
    output logic            busy,
    output logic            done,
    output logic            step_tick,
    output logic [CNTW-1:0] pt_idx,
    output logic            dir
);

    localparam logic [CNTW-1:0] PT_ONE = CNTW'(1);
    localparam logic [DWW-1:0]  DW_ONE = DWW'(1);

    state_e          state_q;
    logic [APR-1:0]  phi_inc_q;
    logic [APR-1:0]  step_inc_q;
    logic [CNTW-1:0] n_last_q;
    logic [DWW-1:0]  dwell_m1_q;
    logic [CNTW-1:0] pt_idx_q;
    logic            clken_q;
    logic            busy_q;
    logic            done_q;
    logic            tick_q;

    logic            tmr_load;
    logic            tmr_dec;
    logic            tmr_zero;
    logic            last_pt;
    logic [APR-1:0]  phi_up_d;
    logic [CNTW-1:0] pt_up_d;

    assign phi_up_d = phi_inc_q + step_inc_q;
    assign pt_up_d  = pt_idx_q + PT_ONE;

`ifdef NCO_SWEEP_BIDIR_EN
    logic            dir_q;
    logic [APR-1:0]  phi_dn_d;
    logic [CNTW-1:0] pt_dn_d;

    assign phi_dn_d = phi_inc_q - step_inc_q;
    assign pt_dn_d  = pt_idx_q - PT_ONE;
    // A one-point sweep never turns; otherwise the sweep ends back at index 0 on the down leg.
    assign last_pt  = (n_last_q == '0) || ((dir_q == DIR_DN) && (pt_idx_q == '0));
    assign dir      = dir_q;
`else
    assign last_pt  = (pt_idx_q == n_last_q);
    assign dir      = DIR_UP;
`endif

    always_comb begin
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        if (!abort) begin
            if (state_q == ST_PRIME && nco_valid) begin
                tmr_load = 1'b1;
            end
            if (state_q == ST_SWEEP) begin
                if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else if (!last_pt) begin
                    tmr_load = 1'b1;
                end
            end
        end
    end

    nco_sweep_timer #(
        .DWW(DWW)
    ) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (tmr_load),
        .load_val_i(dwell_m1_q),
        .dec_i     (tmr_dec),
        .zero_o    (tmr_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            phi_inc_q  <= '0;
            step_inc_q <= '0;
            n_last_q   <= '0;
            dwell_m1_q <= '0;
            pt_idx_q   <= '0;
            clken_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tick_q     <= 1'b0;
`ifdef NCO_SWEEP_BIDIR_EN
            dir_q      <= DIR_UP;
`endif
        end else begin
            done_q <= 1'b0;
            tick_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        phi_inc_q  <= start_inc;
                        step_inc_q <= step_inc;
                        n_last_q   <= (n_pts == '0) ? '0 : n_pts - PT_ONE;
                        dwell_m1_q <= (dwell == '0) ? '0 : dwell - DW_ONE;
                        pt_idx_q   <= '0;
                        clken_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ST_PRIME;
`ifdef NCO_SWEEP_BIDIR_EN
                        dir_q      <= DIR_UP;
`endif
                    end
                end
                ST_PRIME: begin
                    if (abort) begin
                        clken_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (nco_valid) begin
                        state_q <= ST_SWEEP;
                    end
                end
                ST_SWEEP: begin
                    if (abort) begin
                        clken_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (tmr_zero) begin
                        if (last_pt) begin
                            clken_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            tick_q <= 1'b1;
`ifdef NCO_SWEEP_BIDIR_EN
                            if (dir_q == DIR_UP && pt_idx_q != n_last_q) begin
                                phi_inc_q <= phi_up_d;
                                pt_idx_q  <= pt_up_d;
                            end else begin
                                dir_q     <= DIR_DN;
                                phi_inc_q <= phi_dn_d;
                                pt_idx_q  <= pt_dn_d;
                            end
`else
                            phi_inc_q <= phi_up_d;
                            pt_idx_q  <= pt_up_d;
`endif
                        end
                    end
                end
                ST_DONE: begin
                    clken_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    clken_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign phi_inc_o = phi_inc_q;
    assign nco_clken = clken_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign step_tick = tick_q;
    assign pt_idx    = pt_idx_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed and randomized sweeps checked cycle by cycle against an arithmetic trace model.
module tb_nco_sweep_ctrl;

    localparam int APR  = 32;
    localparam int CNTW = 16;
    localparam int DWW  = 16;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [APR-1:0]  start_inc = '0;
    logic [APR-1:0]  step_inc = '0;
    logic [CNTW-1:0] n_pts = '0;
    logic [DWW-1:0]  dwell = '0;
    logic            nco_valid = 1'b0;
    logic [APR-1:0]  phi_inc_o;
    logic            nco_clken;
    logic            busy;
    logic            done;
    logic            step_tick;
    logic [CNTW-1:0] pt_idx;
    logic            dir;

    always #5 clk = ~clk;

    nco_sweep_ctrl #(
        .APR (APR),
        .CNTW(CNTW),
        .DWW (DWW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .abort    (abort),
        .start_inc(start_inc),
        .step_inc (step_inc),
        .n_pts    (n_pts),
        .dwell    (dwell),
        .nco_valid(nco_valid),
        .phi_inc_o(phi_inc_o),
        .nco_clken(nco_clken),
        .busy     (busy),
        .done     (done),
        .step_tick(step_tick),
        .pt_idx   (pt_idx),
        .dir      (dir)
    );

    typedef struct packed {
        logic [APR-1:0]  f_phi;
        logic            f_clken;
        logic            f_busy;
        logic            f_done;
        logic            f_tick;
        logic [CNTW-1:0] f_pt;
        logic            f_dir;
    } obs_t;

    obs_t got;
    always_comb got = {phi_inc_o, nco_clken, busy, done, step_tick, pt_idx, dir};

    int n_pass = 0;
    int n_total = 0;

    // Model of the current sweep: points listed in visit order, each held m_d cycles after m_P prime cycles.
    logic [APR-1:0] m_si;
    logic [APR-1:0] m_st;
    int             m_N;
    int             m_d;
    int             m_P;
    int             m_pts;
    obs_t           m_idle;

    task automatic chk(input string tag, input obs_t exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int pt_of(input int j);
        return (j < m_N) ? j : (2 * m_N - 2 - j);
    endfunction

    function automatic obs_t model(input int c);
        obs_t e;
        int   s;
        int   j;
        int   pt;
        e = '0;
        e.f_busy = 1'b1;
        if (c <= m_P) begin
            pt = 0;
            e.f_clken = 1'b1;
        end else if (c <= m_P + m_pts * m_d) begin
            s = c - m_P - 1;
            j = s / m_d;
            pt = pt_of(j);
            e.f_clken = 1'b1;
            e.f_tick = (j > 0) && (s % m_d == 0);
            e.f_dir = (j >= m_N);
        end else begin
            j = m_pts - 1;
            pt = pt_of(j);
            e.f_done = 1'b1;
            e.f_dir = (j >= m_N);
        end
        e.f_pt = CNTW'(pt);
        e.f_phi = m_si + m_st * APR'(pt);
        return e;
    endfunction

    task automatic idle_check(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            chk($sformatf("%s idle%0d", tag, i), m_idle);
            @(negedge clk);
        end
    endtask

    task automatic run_sweep(input string tag, input logic [APR-1:0] si, input logic [APR-1:0] st,
                             input int n, input int dw, input int p, input int abort_at,
                             input int glitch_at);
        int   len;
        bit   aborted;
        obs_t e;
        m_si = si;
        m_st = st;
        m_N  = (n == 0) ? 1 : n;
        m_d  = (dw == 0) ? 1 : dw;
        m_P  = p;
`ifdef NCO_SWEEP_BIDIR_EN
        m_pts = (m_N > 1) ? (2 * m_N - 1) : m_N;
`else
        m_pts = m_N;
`endif
        len = m_P + m_pts * m_d + 1;
        aborted = 1'b0;
        start = 1'b1;
        abort = 1'b0;
        start_inc = si;
        step_inc = st;
        n_pts = CNTW'(n);
        dwell = DWW'(dw);
        nco_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        start_inc = $urandom;
        step_inc = $urandom;
        n_pts = CNTW'($urandom);
        dwell = DWW'($urandom);
        for (int c = 1; c <= len + 1; c++) begin
            if (c <= len) begin
                e = model(c);
            end else begin
                e = model(len);
                e.f_busy = 1'b0;
                e.f_clken = 1'b0;
                e.f_done = 1'b0;
                e.f_tick = 1'b0;
                m_idle = e;
            end
            chk($sformatf("%s c%0d", tag, c), e);
            if (abort_at != 0 && c == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                e.f_busy = 1'b0;
                e.f_clken = 1'b0;
                e.f_done = 1'b0;
                e.f_tick = 1'b0;
                m_idle = e;
                aborted = 1'b1;
                break;
            end
            nco_valid = (c >= p);
            start = (c == glitch_at);
            @(negedge clk);
        end
        start = 1'b0;
        nco_valid = 1'b0;
        idle_check($sformatf("%s%s", tag, aborted ? " abort" : " end"), 3);
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        m_idle = '0;
        chk("reset held", m_idle);
        reset_n = 1'b1;
        @(negedge clk);
        idle_check("reset released", 2);

        run_sweep("basic", 32'h0100_0000, 32'h0010_0000, 4, 3, 1, 0, 0);
        run_sweep("delayed valid", 32'h0100_0000, 32'h0010_0000, 4, 3, 10, 0, 0);
        run_sweep("wrap", 32'hFFF0_0000, 32'h0020_0000, 2, 3, 1, 0, 0);
        run_sweep("degenerate", 32'h1234_5678, 32'h0000_1000, 0, 0, 1, 0, 0);
        run_sweep("abort pt2", 32'h0100_0000, 32'h0010_0000, 4, 3, 1, 9, 0);

        start = 1'b1;
        abort = 1'b1;
        start_inc = 32'h0ABC_0000;
        nco_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        nco_valid = 1'b0;
        idle_check("start+abort", 4);

        run_sweep("start while busy", 32'h0100_0000, 32'h0010_0000, 4, 3, 2, 0, 6);
        run_sweep("negative step", 32'h0200_0000, 32'hFFF0_0000, 3, 2, 1, 0, 0);
        run_sweep("triangle", 32'h0300_0000, 32'h0001_0000, 3, 2, 1, 0, 0);

        for (int r = 0; r < 8; r++) begin
            run_sweep($sformatf("rand%0d", r), $urandom, $urandom, $urandom_range(0, 5),
                      $urandom_range(0, 4), $urandom_range(1, 4), 0, $urandom_range(1, 8));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
